audio_gain_filter: RTL and testbench

//  Sample-processing stage between the I2S controller's ADC port and its DAC port.

---
 rtl/audio_gain_filter_pkg.sv | 20 ++
 rtl/audio_gain_filter_if.sv | 11 +
 rtl/audio_gain_filter_serial_multiplier.sv | 52 +++++
 rtl/audio_gain_filter.sv | 133 +++++++++++++
 tb/tb_audio_gain_filter.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_gain_filter_pkg.sv
// Shared types and helpers for the audio gain/filter stage: FSM states, default gain
// fraction bits and the saturation helper used on the output path.
package audio_gain_filter_pkg;

   typedef enum logic [1:0] {IDLE_S, FILTER_S, MULT_S} filter_state_e;

   localparam int GAIN_FRAC_BITS = 2;

   // Clamp v to the signed range of a w-bit word.
   function automatic logic signed [31:0] sat(input logic signed [31:0] v, input int w);
      logic signed [31:0] hi;
      logic signed [31:0] lo;
      hi = (32'sd1 <<< (w - 1)) - 32'sd1;
      lo = -(32'sd1 <<< (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/audio_gain_filter_if.sv
// Sample stream between the I2S ADC side and the DAC side: strobe-qualified in/out words.
// No backpressure: the source strobes, the stage strobes its result back.
interface audio_gain_filter_if #(parameter int DataWidth = 12);
   logic signed [DataWidth-1:0] inData;
   logic                        inValid;
   logic signed [DataWidth-1:0] outData;
   logic                        outValid;

   modport master (output inData, inValid, input outData, outValid);
   modport slave  (input inData, inValid, output outData, outValid);
endinterface

// File: rtl/audio_gain_filter_serial_multiplier.sv
// Signed x unsigned shift-add multiplier, one gain bit per cycle LSB first; done_o is high
// in the last step with product_o already including that step. No backpressure.
module audio_gain_filter_serial_multiplier #(
   parameter int AW = 12,
   parameter int BW = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start_i,
   input  logic signed [AW-1:0]   a_i,
   input  logic [BW-1:0]          b_i,
   output logic                   done_o,
   output logic signed [AW+BW:0]  product_o
);
   localparam int PW = AW + BW + 1;
   localparam int CW = (BW > 1) ? $clog2(BW) : 1;

   logic signed [AW-1:0] a_q;
   logic [BW-1:0]        b_q;
   logic signed [PW-1:0] acc_q, acc_d, a_ext, addend;
   logic [CW-1:0]        cnt_q;
   logic                 running_q;

   always_comb begin
      a_ext  = {{(PW-AW){a_q[AW-1]}}, a_q};
      addend = b_q[cnt_q] ? (a_ext <<< cnt_q) : '0;
      acc_d  = acc_q + addend;
   end

   assign done_o    = running_q && (cnt_q == CW'(BW - 1));
   assign product_o = acc_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q       <= '0;
         b_q       <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         running_q <= 1'b0;
      end else if (start_i) begin
         a_q       <= a_i;
         b_q       <= b_i;
         acc_q     <= '0;
         cnt_q     <= '0;
         running_q <= 1'b1;
      end else if (running_q) begin
         acc_q <= acc_d;
         cnt_q <= cnt_q + 1'b1;
         if (done_o) running_q <= 1'b0;
      end
   end
endmodule

// File: rtl/audio_gain_filter.sv
// One-pole IIR low-pass + serial gain + saturation; result strobed GainWidth+2 cycles after accept.
// Inputs arriving while busy are dropped and flagged in overrun; AUDIO_FILTER_CLIP_COUNT_EN adds clipCount.
module audio_gain_filter
   import audio_gain_filter_pkg::*;
#(
   parameter int DataWidth    = 12,
   parameter int GainWidth    = 4,
   parameter int GainFracBits = GAIN_FRAC_BITS,
   parameter int ShiftWidth   = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ShiftWidth-1:0] alphaShift,
   input  logic [GainWidth-1:0]  gain,
   input  logic                  bypass,
   input  logic                  clearStatus,
   audio_gain_filter_if.slave    io,
   output logic                  busy,
   output logic                  overrun
`ifdef AUDIO_FILTER_CLIP_COUNT_EN
   ,
   output logic [7:0]            clipCount
`endif
);
   localparam int AccW = DataWidth + GainWidth + 1;

   filter_state_e               state_q, state_d;
   logic signed [DataWidth-1:0] x_q, y_q, y_d, out_q, out_d;
   logic [ShiftWidth-1:0]       alpha_q;
   logic [GainWidth-1:0]        gain_q;
   logic                        bypass_q, outvld_q, overrun_q, overrun_d;
   logic                        accept, mult_start, mult_done;
   logic signed [DataWidth:0]   diff, step, ysum;
   logic signed [AccW-1:0]      product;
   logic signed [31:0]          acc_ext, r_ext;

   assign accept = (state_q == IDLE_S) && io.inValid;

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE_S;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE_S:   if (io.inValid) state_d = FILTER_S;
         FILTER_S: state_d = MULT_S;
         MULT_S:   if (mult_done) state_d = IDLE_S;
         default:  state_d = IDLE_S;
      endcase
   end

   always_comb begin
      busy       = (state_q != IDLE_S);
      mult_start = (state_q == FILTER_S);
   end

   // Widened difference keeps the arithmetic shift exact; the sum cannot leave the sample range.
   always_comb begin
      diff = $signed({x_q[DataWidth-1], x_q}) - $signed({y_q[DataWidth-1], y_q});
      step = diff >>> alpha_q;
      ysum = $signed({y_q[DataWidth-1], y_q}) + step;
      y_d  = ysum[DataWidth-1:0];
   end

   audio_gain_filter_serial_multiplier #(.AW(DataWidth), .BW(GainWidth)) u_mult (
      .clk       (clk),
      .reset     (reset),
      .start_i   (mult_start),
      .a_i       (y_d),
      .b_i       (gain_q),
      .done_o    (mult_done),
      .product_o (product)
   );

   always_comb begin
      acc_ext   = {{(32-AccW){product[AccW-1]}}, product};
      r_ext     = acc_ext >>> GainFracBits;
      out_d     = bypass_q ? x_q : DataWidth'(sat(r_ext, DataWidth));
      overrun_d = overrun_q;
      if (clearStatus)           overrun_d = 1'b0;
      if (io.inValid && busy)    overrun_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         x_q       <= '0;
         y_q       <= '0;
         alpha_q   <= '0;
         gain_q    <= '0;
         bypass_q  <= 1'b0;
         out_q     <= '0;
         outvld_q  <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         outvld_q  <= mult_done;
         overrun_q <= overrun_d;
         if (accept) begin
            x_q      <= io.inData;
            alpha_q  <= alphaShift;
            gain_q   <= gain;
            bypass_q <= bypass;
         end
         if (state_q == FILTER_S) y_q <= y_d;
         if (mult_done) out_q <= out_d;
      end
   end

   assign io.outData  = out_q;
   assign io.outValid = outvld_q;
   assign overrun     = overrun_q;

`ifdef AUDIO_FILTER_CLIP_COUNT_EN
   logic       clipped;
   logic [7:0] clip_q, clip_base, clip_d;

   always_comb begin
      clipped   = (sat(r_ext, DataWidth) != r_ext);
      clip_base = clearStatus ? 8'd0 : clip_q;
      clip_d    = clip_base;
      if (mult_done && !bypass_q && clipped && (clip_base != 8'hFF))
         clip_d = clip_base + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) clip_q <= '0;
      else       clip_q <= clip_d;
   end

   assign clipCount = clip_q;
`endif
endmodule

// File: tb/tb_audio_gain_filter.sv
// Directed and randomized checks of audio_gain_filter against an arithmetic reference model.
module tb_audio_gain_filter;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] alphaShift = '0;
   logic [3:0] gain = '0;
   logic       bypass = 1'b0;
   logic       clearStatus = 1'b0;
   logic       busy, overrun;
`ifdef AUDIO_FILTER_CLIP_COUNT_EN
   logic [7:0] clipCount;
`endif
   int vectors = 0;
   int miscompares = 0;
   int model_y = 0;
   int model_clip = 0;

   audio_gain_filter_if #(.DataWidth(12)) io ();

   audio_gain_filter dut (
      .clk(clk), .reset(reset), .alphaShift(alphaShift), .gain(gain), .bypass(bypass),
      .clearStatus(clearStatus), .io(io), .busy(busy), .overrun(overrun)
`ifdef AUDIO_FILTER_CLIP_COUNT_EN
      , .clipCount(clipCount)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int floor_div(input int n, input int d);
      return (n >= 0) ? n / d : -((-n + d - 1) / d);
   endfunction

   // Reference: y += floor((x-y)/2^a); out = clamp(floor(y*g/4)), or x when bypassed.
   task automatic model_sample(input int x, input int a, input int g, input bit byp, output int exp_o);
      int r;
      model_y = model_y + floor_div(x - model_y, 1 << a);
      r = floor_div(model_y * g, 4);
      if (byp) exp_o = x;
      else if (r > 2047) exp_o = 2047;
      else if (r < -2048) exp_o = -2048;
      else exp_o = r;
      if (!byp && (r > 2047 || r < -2048) && model_clip < 255) model_clip++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      io.inValid = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      model_y = 0;
      model_clip = 0;
   endtask

   // Strobes one sample in the current cycle, waits up to 20 cycles for the result.
   task automatic run_sample(input int x, input int a, input int g, input bit byp, input bit scramble,
                             output int data, output int lat);
      io.inData = 12'(x);
      alphaShift = 3'(a);
      gain = 4'(g);
      bypass = byp;
      io.inValid = 1'b1;
      lat = -1;
      data = 0;
      for (int c = 1; c <= 20; c++) begin
         tick();
         io.inValid = 1'b0;
         if (scramble) begin
            io.inData = 12'($urandom);
            alphaShift = 3'($urandom);
            gain = 4'($urandom);
            bypass = 1'($urandom);
         end
         if (io.outValid) begin
            data = int'(io.outData);
            lat = c;
            break;
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if (io.outValid !== 1'b0 || io.outData !== 12'sd0 || busy !== 1'b0 || overrun !== 1'b0) begin
         miscompares++;
         $display("FAIL reset: outValid=%b outData=%0d busy=%b overrun=%b, want 0 0 0 0",
                  io.outValid, io.outData, busy, overrun);
      end
`ifdef AUDIO_FILTER_CLIP_COUNT_EN
      vectors++;
      if (clipCount !== 8'd0) begin
         miscompares++;
         $display("FAIL reset_clip: clipCount=%0d want 0", clipCount);
      end
`endif
   endtask

   task automatic test_latency();
      io.inData = 12'sd100; alphaShift = 3'd0; gain = 4'd4; bypass = 1'b0;
      io.inValid = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         tick();
         io.inValid = 1'b0;
         vectors++;
         if (io.outValid !== (c == 6) || busy !== (c >= 1 && c <= 5)) begin
            miscompares++;
            $display("FAIL latency c%0d: outValid=%b busy=%b want %b %b", c, io.outValid, busy,
                     c == 6, c >= 1 && c <= 5);
         end
         if (c == 6) begin
            vectors++;
            if (io.outData !== 12'sd100) begin
               miscompares++;
               $display("FAIL latency_data: got %0d want 100", io.outData);
            end
         end
      end
   endtask

   task automatic test_filter();
      int d, l;
      int exp_v[3] = '{500, 750, 875};
      do_reset();
      for (int i = 0; i < 3; i++) begin
         run_sample(1000, 1, 4, 1'b0, 1'b0, d, l);
         vectors++;
         if (d !== exp_v[i] || l !== 6) begin
            miscompares++;
            $display("FAIL filter%0d: data=%0d lat=%0d want %0d 6", i, d, l, exp_v[i]);
         end
      end
   endtask

   task automatic test_clip();
      int d, l;
      do_reset();
      run_sample(1000, 0, 15, 1'b0, 1'b0, d, l);
      vectors++;
      if (d !== 2047 || l !== 6) begin
         miscompares++;
         $display("FAIL clip_pos: data=%0d lat=%0d want 2047 6", d, l);
      end
      run_sample(-1000, 0, 15, 1'b0, 1'b0, d, l);
      vectors++;
      if (d !== -2048 || l !== 6) begin
         miscompares++;
         $display("FAIL clip_neg: data=%0d lat=%0d want -2048 6", d, l);
      end
      run_sample(1000, 0, 15, 1'b1, 1'b0, d, l);
      vectors++;
      if (d !== 1000 || l !== 6) begin
         miscompares++;
         $display("FAIL bypass: data=%0d lat=%0d want 1000 6", d, l);
      end
`ifdef AUDIO_FILTER_CLIP_COUNT_EN
      vectors++;
      if (clipCount !== 8'd2) begin
         miscompares++;
         $display("FAIL clip_count: clipCount=%0d want 2", clipCount);
      end
`endif
   endtask

   task automatic test_overrun();
      int nvld = 0;
      io.inData = 12'sd10; alphaShift = 3'd0; gain = 4'd4; bypass = 1'b0;
      io.inValid = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         io.inValid = (c == 2);
         if (io.outValid) nvld++;
         if (c == 2 || c == 3) begin
            vectors++;
            if (overrun !== (c == 3)) begin
               miscompares++;
               $display("FAIL overrun c%0d: overrun=%b want %b", c, overrun, c == 3);
            end
         end
      end
      vectors++;
      if (nvld !== 1) begin
         miscompares++;
         $display("FAIL overrun_count: outValid pulses=%0d want 1", nvld);
      end
      clearStatus = 1'b1;
      tick();
      clearStatus = 1'b0;
      vectors++;
      if (overrun !== 1'b0) begin
         miscompares++;
         $display("FAIL overrun_clear: overrun=%b want 0", overrun);
      end
   endtask

   task automatic test_back_to_back();
      io.inData = 12'sd20; alphaShift = 3'd0; gain = 4'd4; bypass = 1'b0;
      io.inValid = 1'b1;
      for (int c = 1; c <= 13; c++) begin
         tick();
         io.inValid = (c == 6);
         vectors++;
         if (io.outValid !== (c == 6 || c == 12) || overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b c%0d: outValid=%b overrun=%b want %b 0", c, io.outValid, overrun,
                     c == 6 || c == 12);
         end
      end
   endtask

   task automatic test_reset_midflight();
      int nvld = 0;
      int d, l;
      io.inData = 12'sd300; alphaShift = 3'd0; gain = 4'd4; bypass = 1'b0;
      io.inValid = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         tick();
         io.inValid = 1'b0;
         reset = (c == 3);
         if (io.outValid) nvld++;
      end
      model_y = 0;
      model_clip = 0;
      vectors++;
      if (nvld !== 0 || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_mid: outValid pulses=%0d busy=%b want 0 0", nvld, busy);
      end
      run_sample(1000, 1, 4, 1'b0, 1'b0, d, l);
      vectors++;
      if (d !== 500 || l !== 6) begin
         miscompares++;
         $display("FAIL reset_mid_next: data=%0d lat=%0d want 500 6", d, l);
      end
   endtask

   task automatic test_random();
      int x, a, g, d, l, e;
      bit b;
      do_reset();
      for (int i = 0; i < 60; i++) begin
         x = int'($urandom_range(0, 4095)) - 2048;
         a = int'($urandom_range(0, 7));
         g = int'($urandom_range(0, 15));
         b = ($urandom_range(0, 3) == 0);
         run_sample(x, a, g, b, 1'b1, d, l);
         model_sample(x, a, g, b, e);
         vectors++;
         if (d !== e || l !== 6) begin
            miscompares++;
            $display("FAIL random%0d: x=%0d a=%0d g=%0d byp=%b data=%0d lat=%0d want %0d 6",
                     i, x, a, g, b, d, l, e);
         end
      end
`ifdef AUDIO_FILTER_CLIP_COUNT_EN
      vectors++;
      if (int'(clipCount) !== model_clip) begin
         miscompares++;
         $display("FAIL random_clip: clipCount=%0d want %0d", clipCount, model_clip);
      end
`endif
   endtask

   initial begin
      io.inData = '0;
      io.inValid = 1'b0;
      #1;
      test_reset();
      test_latency();
      test_filter();
      test_clip();
      test_overrun();
      test_back_to_back();
      test_reset_midflight();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
